// File: rtl/xosera_bus_bridge.sv
// Bridges a 16-bit request/acknowledge register port onto the 8-bit strobed Xosera bus.
// Each word access becomes two byte cycles (even then odd); also holds a sticky interrupt flag.
module xosera_bus_bridge #(
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        req_i,
    output logic        ready_o,
    input  logic        we_i,
    input  logic        byte_mode_i,
    input  logic [3:0]  reg_num_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o,
    output logic        ack_o,
    input  logic        irq_clr_i,
    output logic        irq_o,
    output logic        bus_cs_n_o,
    output logic        bus_rd_nwr_o,
    output logic [3:0]  bus_reg_num_o,
    output logic        bus_bytesel_o,
    output logic [7:0]  bus_data_o,
    input  logic [7:0]  bus_data_i,
    input  logic        bus_intr_i
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Phase counter counts 0..N-1 inside STROBE and HOLD (legal N is 1..15).
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYCLES - 1);

    logic [2:0] state;
    logic [3:0] phase;
    logic       byte_idx;
    logic       lat_byte_mode;
    logic [7:0] wdata_lo;
    logic       intr_s;
    logic       intr_h;

    assign ready_o = (state == ST_IDLE) && reset_n_i;

    // Bus address/data/direction only change on the edge that enters SETUP,
    // so they are settled a full cycle before cs_n falls and through HOLD.
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state         <= ST_IDLE;
            phase         <= 4'd0;
            byte_idx      <= 1'b0;
            lat_byte_mode <= 1'b0;
            wdata_lo      <= 8'h00;
            rdata_o       <= 16'h0000;
            ack_o         <= 1'b0;
            bus_cs_n_o    <= 1'b1;
            bus_rd_nwr_o  <= 1'b1;
            bus_reg_num_o <= 4'd0;
            bus_bytesel_o <= 1'b0;
            bus_data_o    <= 8'h00;
        end else begin
            ack_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        lat_byte_mode <= byte_mode_i;
                        wdata_lo      <= wdata_i[7:0];
                        byte_idx      <= byte_mode_i;
                        bus_reg_num_o <= reg_num_i;
                        bus_rd_nwr_o  <= ~we_i;
                        bus_bytesel_o <= byte_mode_i;
                        bus_data_o    <= byte_mode_i ? wdata_i[7:0] : wdata_i[15:8];
                        state         <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    bus_cs_n_o <= 1'b0;
                    phase      <= 4'd0;
                    state      <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (phase == STROBE_LAST) begin
                        bus_cs_n_o <= 1'b1;
                        phase      <= 4'd0;
                        state      <= ST_HOLD;
                        if (bus_rd_nwr_o) begin
                            if (lat_byte_mode) begin
                                rdata_o <= {8'h00, bus_data_i};
                            end else if (byte_idx) begin
                                rdata_o[7:0] <= bus_data_i;
                            end else begin
                                rdata_o[15:8] <= bus_data_i;
                            end
                        end
                    end else begin
                        phase <= phase + 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (phase == HOLD_LAST) begin
                        phase <= 4'd0;
                        // byte_idx starts at 1 in byte mode, so this only loops for words.
                        if (!byte_idx) begin
                            byte_idx      <= 1'b1;
                            bus_bytesel_o <= 1'b1;
                            bus_data_o    <= wdata_lo;
                            state         <= ST_SETUP;
                        end else begin
                            ack_o <= 1'b1;
                            state <= ST_DONE;
                        end
                    end else begin
                        phase <= phase + 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Interrupt: one input register plus one history register; a new rising
    // edge beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            intr_s <= 1'b0;
            intr_h <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            intr_s <= bus_intr_i;
            intr_h <= intr_s;
            if (intr_s && !intr_h) begin
                irq_o <= 1'b1;
            end else if (irq_clr_i) begin
                irq_o <= 1'b0;
            end
        end
    end

endmodule
